// File: rtl/serv_bufreg2_pkg.sv
// Shared encodings and helpers for the wide SERV second buffer register.
package serv_bufreg2_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int SHAMT_W = 5;

   // Store lanes are replicated so the bus picks the right byte/half by address.
   function automatic logic [31:0] lane_replicate(input logic [31:0] d,
                                                  input logic [1:0]  size);
      case (size)
         SZ_BYTE: return {4{d[7:0]}};
         SZ_HALF: return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/serv_shamt_cnt.sv
// Saturating shift-amount down-counter with done and registered-done flags.
module serv_shamt_cnt
   import serv_bufreg2_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               init,
   input  logic               cnt_done,
   input  logic               shift_op,
   input  logic               load,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               sh_done,
   output logic               sh_done_r
);

   logic [SHAMT_W:0] sh_cnt;

   assign sh_done = (sh_cnt == '0);

   // A parallel bus load owns the cycle, so the shift amount is not taken then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_cnt    <= '0;
         sh_done_r <= 1'b0;
      end else if (en) begin
         sh_done_r <= sh_done;
         if (init && cnt_done && shift_op && !load)
            sh_cnt <= {1'b0, shamt};
         else if (!init && shift_op && !sh_done)
            sh_cnt <= sh_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/serv_bufreg2_wide.sv
// Second buffer register of the SERV datapath, W bits per serial step.
module serv_bufreg2_wide
   import serv_bufreg2_pkg::*;
#(
   parameter int W    = 1,
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic            i_init,
   input  logic            i_cnt_done,
   input  logic [1:0]      i_lsb,
   input  logic            i_byte_valid,
   input  logic [1:0]      i_size,
   input  logic            i_op_b_sel,
   input  logic            i_shift_op,
   input  logic [W-1:0]    i_rs2,
   input  logic [W-1:0]    i_imm,
   output logic [W-1:0]    o_op_b,
   output logic [W-1:0]    o_q,
   output logic            o_sh_done,
   output logic            o_sh_done_r,
   output logic [XLEN-1:0] o_dat,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_dat
);

   logic [XLEN-1:0] dat;
   logic [XLEN-1:0] next_dat;

   assign o_op_b = i_op_b_sel ? i_rs2 : i_imm;

   always_comb begin
      next_dat = dat;
      if (i_load)
         next_dat = i_dat;
      else if (i_en && i_init)
         next_dat = {o_op_b, dat[XLEN-1:W]};
      else if (i_en && !i_shift_op)
         next_dat = {{W{1'b0}}, dat[XLEN-1:W]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         dat <= '0;
      else
         dat <= next_dat;
   end

   // dat[W+4:W] is next_dat[4:0] on a capture step, i.e. the final low bits.
   serv_shamt_cnt u_shamt_cnt (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .en        (i_en),
      .init      (i_init),
      .cnt_done  (i_cnt_done),
      .shift_op  (i_shift_op),
      .load      (i_load),
      .shamt     (dat[W+SHAMT_W-1:W]),
      .sh_done   (o_sh_done),
      .sh_done_r (o_sh_done_r)
   );

   assign o_q   = i_byte_valid ? dat[{i_lsb, 3'b000} +: W] : '0;
   assign o_dat = lane_replicate(dat, i_size);

endmodule

// File: tb/tb_serv_bufreg2_wide.sv
// Directed bench for serv_bufreg2_wide at W=1 and W=4 with a queued scoreboard.
module tb_serv_bufreg2_wide;

   localparam int S_DONE1 = 0, S_DONER1 = 1, S_DAT1 = 2, S_Q1 = 3, S_OPB1 = 4;
   localparam int S_DONE4 = 5, S_DONER4 = 6, S_DAT4 = 7, S_Q4 = 8, S_OPB4 = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en1, en4, init, cnt_done, byte_valid, op_b_sel, shift_op, load;
   logic [1:0]  lsb, size;
   logic        rs2_1, imm_1;
   logic [3:0]  rs2_4, imm_4;
   logic [31:0] dat_in;

   logic        op_b_1, q_1, done_1, done_r_1;
   logic [3:0]  op_b_4, q_4;
   logic        done_4, done_r_4;
   logic [31:0] odat_1, odat_4;

   serv_bufreg2_wide #(.W(1)) u_w1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_init(init), .i_cnt_done(cnt_done),
      .i_lsb(lsb), .i_byte_valid(byte_valid), .i_size(size), .i_op_b_sel(op_b_sel),
      .i_shift_op(shift_op), .i_rs2(rs2_1), .i_imm(imm_1), .o_op_b(op_b_1), .o_q(q_1),
      .o_sh_done(done_1), .o_sh_done_r(done_r_1), .o_dat(odat_1), .i_load(load), .i_dat(dat_in)
   );

   serv_bufreg2_wide #(.W(4)) u_w4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_init(init), .i_cnt_done(cnt_done),
      .i_lsb(lsb), .i_byte_valid(byte_valid), .i_size(size), .i_op_b_sel(op_b_sel),
      .i_shift_op(shift_op), .i_rs2(rs2_4), .i_imm(imm_4), .o_op_b(op_b_4), .o_q(q_4),
      .o_sh_done(done_4), .o_sh_done_r(done_r_4), .o_dat(odat_4), .i_load(load), .i_dat(dat_in)
   );

   // Scoreboard
   logic [31:0] exp_q[$];
   int          sel_q[$];
   string       name_q[$];
   int          n_vec  = 0;
   int          n_miss = 0;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_DONE1:  return {31'b0, done_1};
         S_DONER1: return {31'b0, done_r_1};
         S_DAT1:   return odat_1;
         S_Q1:     return {31'b0, q_1};
         S_OPB1:   return {31'b0, op_b_1};
         S_DONE4:  return {31'b0, done_4};
         S_DONER4: return {31'b0, done_r_4};
         S_DAT4:   return odat_4;
         S_Q4:     return {28'b0, q_4};
         default:  return {28'b0, op_b_4};
      endcase
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         automatic logic [31:0] e = exp_q.pop_front();
         automatic int          s = sel_q.pop_front();
         automatic string       n = name_q.pop_front();
         automatic logic [31:0] a = observe(s);
         n_vec++;
         if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, a, e, $time);
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int sel, input logic [31:0] v, input string name);
      sel_q.push_back(sel);
      exp_q.push_back(v);
      name_q.push_back(name);
   endtask

   task automatic init_w4(input logic [31:0] operand);
      op_b_sel = 1'b0;
      init     = 1'b1;
      shift_op = 1'b1;
      en4      = 1'b1;
      for (int i = 0; i < 8; i++) begin
         imm_4    = operand[4*i +: 4];
         cnt_done = (i == 7);
         tick();
      end
      init     = 1'b0;
      cnt_done = 1'b0;
      en4      = 1'b0;
   endtask

   initial begin
      automatic logic [3:0]  q_tab  = 4'b0101;
      automatic logic [31:0] shv    = 32'h0000_001F;
      automatic int          n_en   = 0;
      automatic int          budget = 0;

      rst_n = 1'b0; en1 = 0; en4 = 0; init = 0; cnt_done = 0; byte_valid = 1'b1;
      op_b_sel = 0; shift_op = 0; load = 0; lsb = 2'd0; size = 2'b10;
      rs2_1 = 0; imm_1 = 0; rs2_4 = 4'h0; imm_4 = 4'h0; dat_in = 32'h0;

      // Reset and idle
      tick();
      chk(S_DONE1, 32'd1, "rst_done1");
      chk(S_DONER1, 32'd0, "rst_done_r1");
      chk(S_DAT1, 32'd0, "rst_dat1");
      chk(S_Q1, 32'd0, "rst_q1");
      chk(S_DONE4, 32'd1, "rst_done4");
      rst_n = 1'b1;
      tick();
      chk(S_DONE1, 32'd1, "idle_done1");
      chk(S_DONER1, 32'd0, "idle_done_r1");
      chk(S_DAT1, 32'd0, "idle_dat1");

      // Operand B mux
      op_b_sel = 1'b1; rs2_1 = 1'b1; imm_1 = 1'b0; rs2_4 = 4'hA; imm_4 = 4'h3;
      chk(S_OPB1, 32'd1, "opb1_rs2");
      chk(S_OPB4, 32'hA, "opb4_rs2");
      tick();
      op_b_sel = 1'b0;
      chk(S_OPB1, 32'd0, "opb1_imm");
      chk(S_OPB4, 32'h3, "opb4_imm");
      tick();

      // Parallel load and lane readback
      dat_in = 32'hAABB_CCDD; load = 1'b1;
      tick();
      load = 1'b0;
      chk(S_DAT1, 32'hAABB_CCDD, "load_word1");
      for (int i = 0; i < 4; i++) begin
         lsb = 2'(i);
         chk(S_Q1, {31'b0, q_tab[i]}, "q1_lane");
         tick();
      end
      lsb = 2'd1;
      chk(S_Q4, 32'hC, "q4_lane1");
      tick();
      lsb = 2'd3;
      chk(S_Q4, 32'hA, "q4_lane3");
      tick();
      byte_valid = 1'b0;
      chk(S_Q4, 32'h0, "q4_invalid");
      chk(S_Q1, 32'h0, "q1_invalid");
      tick();
      byte_valid = 1'b1; lsb = 2'd0;

      // Lane replication
      dat_in = 32'h1234_56AB; load = 1'b1;
      tick();
      load = 1'b0;
      size = 2'b00; chk(S_DAT1, 32'hABAB_ABAB, "size_byte");
      tick();
      size = 2'b01; chk(S_DAT1, 32'h56AB_56AB, "size_half");
      tick();
      size = 2'b11; chk(S_DAT1, 32'h1234_56AB, "size_rsvd");
      tick();
      size = 2'b10;

      // W=4 shift amount 5 from immediate
      init_w4(32'h0000_0005);
      chk(S_DAT4, 32'h0000_0005, "w4_capture");
      chk(S_DONE4, 32'd0, "w4_done_after_init");
      chk(S_DONER4, 32'd1, "w4_done_r_after_init");
      shift_op = 1'b1; en4 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk(S_DONE4, {31'b0, k >= 5}, "w4_done_count");
         chk(S_DONER4, {31'b0, k >= 6}, "w4_done_r_count");
      end
      en4 = 1'b0;
      tick();

      // W=1 shift amount 31 from rs2, enable toggling
      op_b_sel = 1'b1; init = 1'b1; shift_op = 1'b1; en1 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs2_1    = shv[i];
         cnt_done = (i == 31);
         tick();
      end
      init = 1'b0; cnt_done = 1'b0; en1 = 1'b0;
      chk(S_DAT1, 32'h0000_001F, "w1_capture");
      chk(S_DONE1, 32'd0, "w1_done_after_init");
      for (int c = 0; c < 64; c++) begin
         en1 = (c % 2 == 0);
         if (en1) n_en++;
         tick();
         chk(S_DONE1, {31'b0, n_en >= 31}, "w1_done_count");
      end
      en1 = 1'b0;
      tick();

      // Asynchronous reset in the middle of a count
      init_w4(32'h0000_0005);
      shift_op = 1'b1; en4 = 1'b1;
      tick();
      tick();
      en4 = 1'b0;
      chk(S_DONE4, 32'd0, "midcount_done");
      tick();
      rst_n = 1'b0;
      #1;
      chk(S_DONE4, 32'd1, "async_rst_done");
      chk(S_DONER4, 32'd0, "async_rst_done_r");
      chk(S_DAT4, 32'd0, "async_rst_dat");
      tick();
      rst_n = 1'b1;
      tick();

      // Load together with init keeps the shift count
      init_w4(32'h0000_0005);
      dat_in = 32'hCAFE_F00D; load = 1'b1; init = 1'b1; cnt_done = 1'b1;
      shift_op = 1'b1; en4 = 1'b1; op_b_sel = 1'b0; imm_4 = 4'h0;
      tick();
      load = 1'b0; init = 1'b0; cnt_done = 1'b0; en4 = 1'b0;
      chk(S_DAT4, 32'hCAFE_F00D, "load_over_init_dat");
      chk(S_DONE4, 32'd0, "load_over_init_cnt");
      tick();

      // Non-shift step serialises store data and leaves the count alone
      shift_op = 1'b0; en4 = 1'b1;
      tick();
      en4 = 1'b0;
      chk(S_DAT4, 32'h0CAF_EF00, "store_shift_dat");
      chk(S_DONE4, 32'd0, "store_shift_cnt");
      tick();

      while (exp_q.size() > 0 && budget < 10) begin
         @(negedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/serv_bufreg2_wide.md
Name: serv_bufreg2_wide

Overview:
Parametrised successor to the second buffer register in the SERV bit-serial datapath, supporting W bits per cycle (W = 1, 2, 4, 8).
- Serially captures operand B (rs2 or immediate) into a 32-bit buffer.
- Runs a dedicated shift-amount down-counter for shift instructions.
- Presents store data with byte/half-word lane replication.
- Captures load data from the bus in one cycle.
- Sits between the decoder/register file and the ALU/memory interface.

Parameters:
W, 1, datapath bits per cycle; legal values 1, 2, 4, 8 (32 % W == 0).
XLEN, 32, buffer width; fixed at 32 in this generation.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  serial step enable
i_init  input  1  operand capture phase
i_cnt_done  input  1  last cycle of the current serial phase
i_lsb  input  2  byte offset of the memory access
i_byte_valid  input  1  current serial cycle lies inside the addressed byte lane
i_size  input  2  store size: 00 byte, 01 half, 10 word
i_op_b_sel  input  1  1 = rs2, 0 = immediate
i_shift_op  input  1  current instruction is a shift
i_rs2  input  W  serial rs2 bits
i_imm  input  W  serial immediate bits
o_op_b  output  W  selected operand B
o_q  output  W  serial store/readback data
o_sh_done  output  1  shift count exhausted
o_sh_done_r  output  1  o_sh_done registered by one cycle
o_dat  output  32  store data, lane-replicated
i_load  input  1  parallel load strobe
i_dat  input  32  load data from bus

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - dat = 0, sh_cnt = 0, o_sh_done_r = 0.
  - Hence o_sh_done = 1, o_q = 0, o_dat = 0.
  - A reset asserted mid-instruction aborts capture and counting immediately; there is no partial state.
- o_op_b: i_op_b_sel ? i_rs2 : i_imm. Combinational, zero latency.
- dat update priority:
  1. i_load = 1: dat <= i_dat. Overrides i_en and i_init in the same cycle.
  2. i_en & i_init: dat <= {o_op_b, dat[31:W]}. After 32/W enabled init cycles, dat holds the full operand, LSB at bit 0.
  3. i_en & !i_init & !i_shift_op: dat <= {W'b0, dat[31:W]} (store serialisation).
  4. Otherwise dat holds.
- Shift counter sh_cnt[5:0]:
  - Load: when i_en & i_init & i_cnt_done & i_shift_op, sh_cnt <= {1'b0, next_dat[4:0]}, where next_dat[4:0] = dat[W+4:W] (the value dat takes at that same edge).
  - Count: when i_en & !i_init & i_shift_op & (sh_cnt != 0), sh_cnt <= sh_cnt - 1. It decrements by one per enabled cycle independent of W and saturates at 0 (no wrap).
  - o_sh_done = (sh_cnt == 0), combinational.
  - o_sh_done_r <= o_sh_done on every edge when i_en, else holds.
  - shamt 0 gives o_sh_done = 1 in the first post-init cycle.
  - shamt 31 gives o_sh_done rising exactly 31 enabled cycles after init.
- o_q = i_byte_valid ? dat[8*i_lsb +: W] : W'b0. Combinational.
- o_dat:
  - size 00: {4{dat[7:0]}}
  - size 01: {2{dat[15:0]}}
  - size 10: dat
  - size 11: reserved, drives dat.
- Boundary cases:
  - i_load together with i_init: load wins, and sh_cnt is not loaded.
  - i_en low: all state holds, including sh_cnt.
  - Non-shift instructions never modify sh_cnt.

Decomposition:
- serv_bufreg2_pkg holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - SHAMT_W = 5;
  - a function for lane replication.
- One natural sub-module, serv_shamt_cnt: a 6-bit saturating down-counter plus the done/done_r flags.

Test Plan:
- W=1, reset low then high, idle → o_sh_done = 1, o_sh_done_r = 0, o_dat = 0, o_q = 0.
- W=1, i_load with i_dat = 0xAABBCCDD, i_size = 10, then i_lsb = 0..3 with i_byte_valid = 1 → o_dat = 0xAABBCCDD, o_q = 1, 0, 1, 0 (dat[0], dat[8], dat[16], dat[24]).
- W=4, i_op_b_sel = 0, 8 init cycles feeding imm nibbles of 0x00000005, with i_shift_op and i_cnt_done on the 8th → dat = 0x5, sh_cnt = 5, o_sh_done low for 5 enabled cycles then high; o_sh_done_r rises one cycle later.
- W=1, i_op_b_sel = 1, rs2 = 0x0000001F captured, then i_en toggled on/off → o_sh_done only after 31 enabled cycles, and sh_cnt holds while i_en = 0.
- i_size = 00 with dat = 0x123456AB → o_dat = 0xABABABAB; i_size = 01 → o_dat = 0x56AB56AB.
- Assert i_rst_n low mid-count (sh_cnt = 3) → o_sh_done = 1 immediately, with no clock edge needed; i_load and i_init together → dat = i_dat and sh_cnt unchanged.
